// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU among N_REQ requesters, one operation in flight.
// Optional BUSY watchdog is enabled by defining ALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_A,
  input  logic [8*N_REQ-1:0]   req_B,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 alu_start,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant, grant, pick, idx;
  logic            pick_vld;
  logic [7:0]      a_arr  [N_REQ];
  logic [7:0]      b_arr  [N_REQ];
  logic [2:0]      op_arr [N_REQ];
  logic [2:0]      pick_op;
  logic            pick_op_ok;
  logic [7:0]      a_q, b_q;
  logic [2:0]      op_q;
  logic [15:0]     result_q;
  logic            err_q;
  logic            tmo_hit;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i]  = req_A[8*i +: 8];
      b_arr[i]  = req_B[8*i +: 8];
      op_arr[i] = req_op[3*i +: 3];
    end
  end

  // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_op    = op_arr[pick];
  assign pick_op_ok = (pick_op == 3'b001) || (pick_op == 3'b010) ||
                      (pick_op == 3'b011) || (pick_op == 3'b100);

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if (state == BUSY && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_hit = (state == BUSY) && !alu_done && (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = pick_op_ok ? BUSY : RESP;
      BUSY: if (alu_done || tmo_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = 16'h0000;
    rsp_err    = 1'b0;
    alu_start  = (state == BUSY);
    if (state == IDLE && pick_vld) req_ready[pick] = 1'b1;
    if (state == RESP) begin
      rsp_valid[grant] = 1'b1;
      rsp_result       = result_q;
      rsp_err          = err_q;
    end
  end

  assign alu_A  = a_q;
  assign alu_B  = b_q;
  assign alu_op = op_q;

  // ALU-facing operand regs only change on a forwarded op, so they hold across invalid ops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GW'(N_REQ - 1);
      grant      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          last_grant <= pick;
          grant      <= pick;
          result_q   <= '0;
          err_q      <= !pick_op_ok;
          if (pick_op_ok) begin
            a_q  <= a_arr[pick];
            b_q  <= b_arr[pick];
            op_q <= pick_op;
          end
        end
        BUSY: begin
          if (alu_done)     result_q <= alu_result;
          else if (tmo_hit) err_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter: vector table of single requests plus
// multi-requester, fairness, async-reset and (ALU_ARB_TIMEOUT_EN) timeout sequences.
module tb_tinyalu_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [8*N-1:0] req_A, req_B;
  logic [3*N-1:0] req_op;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_result;
  logic          rsp_err;
  logic          alu_start;
  logic [7:0]    alu_A, alu_B;
  logic [2:0]    alu_op;
  logic          alu_done = 1'b0;
  logic [15:0]   alu_result = '0;

  logic [7:0] a_in  [N];
  logic [7:0] b_in  [N];
  logic [2:0] op_in [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_A[8*g +: 8]  = a_in[g];
    assign req_B[8*g +: 8]  = b_in[g];
    assign req_op[3*g +: 3] = op_in[g];
  end

  tinyalu_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  // TinyALU stand-in: done after alu_lat start cycles, never if alu_hang.
  int alu_lat  = 1;
  bit alu_hang = 1'b0;
  int alu_cnt  = 0;

  always @(negedge clk) begin
    if (!alu_start) begin
      alu_done = 1'b0;
      alu_cnt  = 0;
    end else if (alu_done) begin
      alu_done = 1'b0;
    end else if (!alu_hang) begin
      alu_cnt++;
      if (alu_cnt >= alu_lat) begin
        alu_done = 1'b1;
        case (alu_op)
          3'b001:  alu_result = {8'h00, alu_A} + {8'h00, alu_B};
          3'b010:  alu_result = {8'h00, alu_A & alu_B};
          3'b011:  alu_result = {8'h00, alu_A ^ alu_B};
          3'b100:  alu_result = alu_A * alu_B;
          default: alu_result = 16'hDEAD;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    int          lat;
    logic [15:0] res;
    bit          err;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] last_a = '0, last_b = '0;
  logic [2:0] last_op = '0;

  task automatic do_req(input vec_t v);
    int waited;
    @(negedge clk);
    a_in[v.idx] = v.a; b_in[v.idx] = v.b; op_in[v.idx] = v.op;
    req_valid[v.idx] = 1'b1;
    alu_lat = v.lat;
    #1;
    waited = 0;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk("ready_onehot", req_ready, 32'(1) << v.idx);
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    #1;
    if (v.err) begin
      chk("inv_no_start", alu_start, 0);
      chk("inv_rsp_valid", rsp_valid, 32'(1) << v.idx);
      chk("inv_rsp_result", rsp_result, 0);
      chk("inv_rsp_err", rsp_err, 1);
      chk("inv_hold_A", alu_A, last_a);
      chk("inv_hold_op", alu_op, last_op);
    end else begin
      chk("start_latency", alu_start, 1);
      chk("alu_A", alu_A, v.a);
      chk("alu_B", alu_B, v.b);
      chk("alu_op", alu_op, v.op);
      last_a = v.a; last_b = v.b; last_op = v.op;
      waited = 0;
      while (rsp_valid == '0 && waited < 40) begin
        @(negedge clk); #1; waited++;
      end
      chk("rsp_latency", waited, v.lat);
      chk("rsp_valid", rsp_valid, 32'(1) << v.idx);
      chk("rsp_result", rsp_result, v.res);
      chk("rsp_err", rsp_err, 0);
      chk("start_gap", alu_start, 0);
    end
    @(negedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  // seq holds expected grant indices, one per nibble, first grant in the low nibble.
  task automatic run_multi(input logic [N-1:0] mask, input bit keep, input int n,
                           input logic [15:0] seq, input logic [15:0] exp_res);
    int grants, rsps, cyc;
    logic [N-1:0] clr;
    logic [15:0] sh;
    grants = 0; rsps = 0; cyc = 0; clr = '0;
    @(negedge clk);
    req_valid = mask;
    #1;
    while (rsps < n && cyc < 200) begin
      if (req_ready != '0 && grants < n) begin
        sh = seq >> (4 * grants);
        chk("grant_order", req_ready, 32'(1) << sh[3:0]);
        grants++;
        clr = (grants == n) ? '1 : (keep ? '0 : req_ready);
      end
      if (rsp_valid != '0) begin
        chk("rsp_onehot", 32'($onehot(rsp_valid)), 1);
        chk("multi_result", rsp_result, exp_res);
        rsps++;
      end
      @(negedge clk);
      req_valid = req_valid & ~clr;
      clr = '0;
      #1;
      cyc++;
    end
    chk("multi_rsp_count", rsps, n);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0; b_in[i] = '0; op_in[i] = '0;
    end
    vecs[0] = '{0, 8'd200, 8'd100, 3'b001, 1, 16'd300,  1'b0};
    vecs[1] = '{1, 8'hF0,  8'h3C,  3'b010, 2, 16'h0030, 1'b0};
    vecs[2] = '{2, 8'hF0,  8'h3C,  3'b011, 3, 16'h00CC, 1'b0};
    vecs[3] = '{3, 8'hFF,  8'hFF,  3'b100, 4, 16'hFE01, 1'b0};
    vecs[4] = '{3, 8'd5,   8'd6,   3'b111, 1, 16'h0000, 1'b1};
    vecs[5] = '{0, 8'd5,   8'd6,   3'b000, 1, 16'h0000, 1'b1};
    vecs[6] = '{1, 8'd5,   8'd6,   3'b101, 1, 16'h0000, 1'b1};
    vecs[7] = '{2, 8'hFF,  8'h01,  3'b001, 1, 16'h0100, 1'b0};
    vecs[8] = '{0, 8'd12,  8'd10,  3'b100, 2, 16'd120,  1'b0};
    vecs[9] = '{2, 8'd5,   8'd6,   3'b110, 1, 16'h0000, 1'b1};

    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_ops", {alu_A, alu_B, alu_op}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // All four requesters at once, mul FF*FF; grants start at requester 0.
    for (int i = 0; i < N; i++) begin
      a_in[i] = 8'hFF; b_in[i] = 8'hFF; op_in[i] = 3'b100;
    end
    alu_lat = 2;
    run_multi(4'b1111, 1'b0, 4, 16'h3210, 16'hFE01);
    last_a = 8'hFF; last_b = 8'hFF; last_op = 3'b100;

    for (int i = 0; i < 10; i++) do_req(vecs[i]);

    // Fairness: last grant = 1, then req1 and req2 held valid.
    do_req('{1, 8'd1, 8'd2, 3'b001, 1, 16'd3, 1'b0});
    for (int i = 0; i < N; i++) begin
      a_in[i] = 8'd1; b_in[i] = 8'd2; op_in[i] = 3'b001;
    end
    alu_lat = 1;
    run_multi(4'b0110, 1'b1, 4, 16'h1212, 16'd3);

    // Async reset while BUSY.
    alu_hang = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1;
    #1;
    chk("rstmid_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    chk("rstmid_busy", alu_start, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_start_drop", alu_start, 0);
    chk("rstmid_no_rsp", rsp_valid, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (rsp_valid != '0) cnt++;
    end
    chk("rstmid_no_rsp_later", cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    alu_hang = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_in[i] = 8'hFF; b_in[i] = 8'hFF; op_in[i] = 3'b100;
    end
    alu_lat = 1;
    run_multi(4'b1111, 1'b0, 1, 16'h0000, 16'hFE01);
    last_a = 8'hFF; last_b = 8'hFF; last_op = 3'b100;

`ifdef ALU_ARB_TIMEOUT_EN
    alu_hang = 1'b1;
    @(negedge clk);
    a_in[0] = 8'd7; b_in[0] = 8'd8; op_in[0] = 3'b001;
    req_valid[0] = 1'b1;
    #1;
    chk("tmo_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    cnt = 0;
    while (alu_start && cnt < 40) begin
      cnt++;
      @(negedge clk); #1;
    end
    chk("tmo_start_cycles", cnt, 15);
    chk("tmo_rsp_valid", rsp_valid, 4'b0001);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_result", rsp_result, 0);
    alu_hang = 1'b0;
    last_a = 8'd7; last_b = 8'd8; last_op = 3'b001;
    do_req('{2, 8'd9, 8'd3, 3'b011, 2, 16'h000A, 1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
